user_project_wrapper: RTL and testbench

USER_PROJECT_WRAPPER -- requirements
Module: user_project_wrapper

---
 rtl/user_project_wrapper.sv | 242 ++++++++++++++++++++++++
 tb/tb_user_project_wrapper.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/user_project_wrapper.sv
// Harness wrapper: bring-up reset generator, bit-serial SPI loader into a 64x16 RAM,
// and a tiny three-phase program executor driving three GPIO pads.
module user_project_wrapper (
    inout  wire          vdda1,
    inout  wire          vdda2,
    inout  wire          vssa1,
    inout  wire          vssa2,
    inout  wire          vccd1,
    inout  wire          vccd2,
    inout  wire          vssd1,
    inout  wire          vssd2,
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oenb,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    inout  wire  [28:0]  analog_io,
    input  logic         user_clock2,
    output logic [2:0]   user_irq
);

    localparam int unsigned ADDR_W     = 24;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned PC_W       = 6;
    localparam int unsigned RAM_DEPTH  = 64;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CW_RST_CYC = 16;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_ADDR,
        SPI_WE,
        SPI_DATA,
        SPI_COMMIT
    } spi_state_e;

    typedef enum logic [1:0] {
        EX_FETCH,
        EX_ARG,
        EX_EXEC
    } ex_state_e;

    // Bus side is idle; upstream bus signals are not used.
    logic cw_dir;
    logic unused_ok;

    assign cw_dir      = 1'b0;
    assign wbs_ack_o   = 1'b0;
    assign wbs_dat_o   = '0;
    assign la_data_out = '0;
    assign user_irq    = '0;

    // Reset generator and synchronizers
    logic [CNT_W-1:0] cw_cnt_q, cw_cnt_d;
    logic             cw_rst_q, cw_rst_d;
    logic [3:0]       sync1_q, sync2_q;
    logic             sclk_prev_q;
    logic             core_dis_s, embed_s, sclk_s, mosi_s;
    logic             spi_rise_c, run_c;

    assign {mosi_s, sclk_s, embed_s, core_dis_s} = sync2_q;
    assign spi_rise_c = sclk_s & ~sclk_prev_q & ~cw_rst_q;
    assign run_c      = embed_s & ~core_dis_s;

    always_comb begin
        cw_cnt_d = cw_cnt_q;
        if (cw_cnt_q != CNT_W'(CW_RST_CYC)) cw_cnt_d = cw_cnt_q + CNT_W'(1);
        cw_rst_d = (cw_cnt_q < CNT_W'(CW_RST_CYC - 1));
    end

    // SPI slave
    spi_state_e        spi_state_q, spi_state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              miso_q, miso_d;
    logic              ram_we_c;

    always_comb begin
        spi_state_d = spi_state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        miso_d      = miso_q;
        ram_we_c    = 1'b0;
        case (spi_state_q)
            SPI_IDLE: begin
                if (spi_rise_c && !mosi_s) begin
                    spi_state_d = SPI_ADDR;
                    bit_cnt_d   = '0;
                    miso_d      = 1'b1;
                end
            end
            SPI_ADDR: begin
                if (spi_rise_c) begin
                    addr_d = {mosi_s, addr_q[ADDR_W-1:1]};
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        spi_state_d = SPI_WE;
                        bit_cnt_d   = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            SPI_WE: begin
                if (spi_rise_c) begin
                    if (mosi_s) begin
                        spi_state_d = SPI_DATA;
                        bit_cnt_d   = '0;
                    end else begin
                        spi_state_d = SPI_IDLE;
                        miso_d      = 1'b0;
                    end
                end
            end
            SPI_DATA: begin
                if (spi_rise_c) begin
                    data_d = {mosi_s, data_q[DATA_W-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        spi_state_d = SPI_COMMIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            SPI_COMMIT: begin
                ram_we_c    = addr_q[ADDR_W-1];
                miso_d      = 1'b0;
                spi_state_d = SPI_IDLE;
            end
            default: spi_state_d = SPI_IDLE;
        endcase
    end

    // Program RAM: no reset, async read returns the pre-write word on a same-cycle write
    logic [DATA_W-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge wb_clk_i) begin
        if (ram_we_c) mem_q[addr_q[PC_W-1:0]] <= data_q;
    end

    // Executor
    ex_state_e         ex_state_q, ex_state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [DATA_W-1:0] arg_q, arg_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [2:0]        gpio_q, gpio_d;

    always_comb begin
        ex_state_d = ex_state_q;
        pc_d       = pc_q;
        op_d       = op_q;
        arg_d      = arg_q;
        acc_d      = acc_q;
        gpio_d     = gpio_q;
        if (run_c) begin
            case (ex_state_q)
                EX_FETCH: begin
                    op_d       = mem_q[pc_q];
                    ex_state_d = EX_ARG;
                end
                EX_ARG: begin
                    arg_d      = mem_q[pc_q + PC_W'(1)];
                    ex_state_d = EX_EXEC;
                end
                EX_EXEC: begin
                    pc_d       = pc_q + PC_W'(2);
                    ex_state_d = EX_FETCH;
                    case (op_q)
                        16'h0001: acc_d  = arg_q;
                        16'h0002: gpio_d = acc_q[2:0];
                        16'h0003: acc_d  = {14'b0, io_in[5:4]};
                        16'h0004: pc_d   = arg_q[PC_W-1:0];
                        16'h0005: acc_d  = acc_q >> arg_q[3:0];
                        default:  ;
                    endcase
                end
                default: ex_state_d = EX_FETCH;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cw_cnt_q    <= '0;
            cw_rst_q    <= 1'b1;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sclk_prev_q <= 1'b0;
            spi_state_q <= SPI_IDLE;
            bit_cnt_q   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            miso_q      <= 1'b0;
            ex_state_q  <= EX_FETCH;
            pc_q        <= '0;
            op_q        <= '0;
            arg_q       <= '0;
            acc_q       <= '0;
            gpio_q      <= '0;
        end else begin
            cw_cnt_q    <= cw_cnt_d;
            cw_rst_q    <= cw_rst_d;
            sync1_q     <= {io_in[35], io_in[34], io_in[33], io_in[32]};
            sync2_q     <= sync1_q;
            sclk_prev_q <= sclk_s;
            spi_state_q <= spi_state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            miso_q      <= miso_d;
            ex_state_q  <= ex_state_d;
            pc_q        <= pc_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            acc_q       <= acc_d;
            gpio_q      <= gpio_d;
        end
    end

    // Pad mapping: cw_clk, miso, cw_rst, idle bus, gpio
    assign io_out = {wb_clk_i, miso_q, 6'b0, cw_rst_q, 3'b0, 16'b0, cw_dir, 1'b0, 5'b0, gpio_q};
    assign io_oeb = {2'b00, 6'h3F, 2'b00, 2'b11, {16{cw_dir}}, 2'b00, 5'h1F, 3'b000};

    assign unused_ok = ^{vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2, analog_io,
                         user_clock2, wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
                         wbs_adr_i, la_data_in, la_oenb, io_in[37:36], io_in[31:6], io_in[3:0],
                         addr_q[ADDR_W-2:PC_W]};

endmodule

// File: tb/tb_user_project_wrapper.sv
// Directed bench for user_project_wrapper: reset generator, SPI RAM loader and executor programs.
`timescale 1ns/1ps
module tb_user_project_wrapper;

    logic         clk;
    logic         rst;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] la_data_out;
    logic [2:0]   user_irq;
    wire          pwr = 1'b1;
    wire          gnd = 1'b0;
    wire  [28:0]  analog_io = '0;

    int n_checks = 0;
    int n_pass   = 0;

    user_project_wrapper dut (
        .vdda1(pwr), .vdda2(pwr), .vssa1(gnd), .vssa2(gnd),
        .vccd1(pwr), .vccd2(pwr), .vssd1(gnd), .vssd2(gnd),
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(1'b0), .wbs_cyc_i(1'b0), .wbs_we_i(1'b0), .wbs_sel_i(4'h0),
        .wbs_dat_i(32'h0), .wbs_adr_i(32'h0), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .la_data_in(128'h0), .la_data_out(la_data_out), .la_oenb(128'h0),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
        .analog_io(analog_io), .user_clock2(1'b0), .user_irq(user_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic spi_bit(input logic b);
        io_in[35] = b;
        tick(3);
        io_in[34] = 1'b1;
        tick(3);
        io_in[34] = 1'b0;
    endtask

    task automatic spi_frame(input logic [23:0] addr, input logic we, input logic [15:0] data,
                             input logic chk_miso);
        spi_bit(1'b0);
        if (chk_miso) chk("miso_after_start", 64'(io_out[36]), 64'd1);
        for (int i = 0; i < 24; i++) spi_bit(addr[i]);
        if (chk_miso) chk("miso_mid_frame", 64'(io_out[36]), 64'd1);
        spi_bit(we);
        if (we) for (int i = 0; i < 16; i++) spi_bit(data[i]);
        io_in[35] = 1'b1;
        tick(6);
    endtask

    task automatic wait_gpio(input string tag, input logic [2:0] val);
        for (int i = 0; i < 400; i++) begin
            if (io_out[2:0] == val) break;
            tick(1);
        end
        chk(tag, 64'(io_out[2:0]), 64'(val));
    endtask

    logic [15:0] prog [10];
    logic [23:0] a;
    logic [15:0] d;

    initial begin
        prog = '{16'h0001, 16'h0005, 16'h0002, 16'h0000, 16'h0003,
                 16'h0000, 16'h0002, 16'h0000, 16'h0004, 16'h0008};
        io_in     = '0;
        io_in[35] = 1'b1;
        io_in[32] = 1'b1;
        io_in[5:4] = 2'b10;
        rst = 1'b1;
        tick(3);
        chk("rst_cw_rst", 64'(io_out[29]), 64'd1);
        chk("rst_gpio", 64'(io_out[2:0]), 64'd0);
        chk("rst_miso", 64'(io_out[36]), 64'd0);
        chk("oeb", 64'(io_oeb), 64'h0F_CC00_00F8);
        chk("tieoffs", {31'b0, wbs_ack_o, wbs_dat_o} | 64'(user_irq) | 64'(|la_data_out), 64'd0);

        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick(1);
            chk($sformatf("cw_rst_cyc%0d", i), 64'(io_out[29]), (i < 16) ? 64'd1 : 64'd0);
        end
        chk("idle_pads", {26'b0, io_out[35:30], io_out[28:3]}, 64'd0);
        chk("cw_clk_hi", 64'(io_out[37]), 64'd1);
        @(negedge clk); #1;
        chk("cw_clk_lo", 64'(io_out[37]), 64'd0);
        tick(1);

        // Committed write, then a discarded write and a read-only frame
        spi_frame(24'h800003, 1'b1, 16'hBEEF, 1'b1);
        chk("miso_after_commit", 64'(io_out[36]), 64'd0);
        chk("ram3_beef", 64'(dut.mem_q[3]), 64'hBEEF);
        spi_frame(24'h000003, 1'b1, 16'h1234, 1'b0);
        spi_frame(24'h800003, 1'b0, 16'h0000, 1'b0);
        chk("miso_after_rd", 64'(io_out[36]), 64'd0);
        chk("ram3_kept", 64'(dut.mem_q[3]), 64'hBEEF);

        // Reset partway through the data bits aborts the frame
        spi_frame(24'h800005, 1'b1, 16'hAAAA, 1'b0);
        a = 24'h800005;
        d = 16'h5555;
        spi_bit(1'b0);
        for (int i = 0; i < 24; i++) spi_bit(a[i]);
        spi_bit(1'b1);
        for (int i = 0; i < 10; i++) spi_bit(d[i]);
        rst = 1'b1;
        io_in[35] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(24);
        chk("abort_ram5", 64'(dut.mem_q[5]), 64'hAAAA);
        chk("abort_miso", 64'(io_out[36]), 64'd0);

        // Main program
        for (int i = 0; i < 10; i++) spi_frame(24'h800000 + 24'(i), 1'b1, prog[i], 1'b0);
        io_in[33] = 1'b1;
        tick(10);
        chk("frozen_gpio", 64'(io_out[2:0]), 64'd0);
        io_in[32] = 1'b0;
        wait_gpio("run_out1", 3'b101);
        wait_gpio("run_out2", 3'b010);
        tick(40);
        chk("run_loop_hold", 64'(io_out[2:0]), 64'd2);

        // Same program, frozen right after the first OUT
        io_in[32] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        chk("rerst_gpio", 64'(io_out[2:0]), 64'd0);
        rst = 1'b0;
        tick(20);
        io_in[32] = 1'b0;
        wait_gpio("frz_out1", 3'b101);
        io_in[32] = 1'b1;
        tick(40);
        chk("frz_hold", 64'(io_out[2:0]), 64'd5);
        io_in[32] = 1'b0;
        wait_gpio("frz_resume", 3'b010);

        // PC wrap from 62 to 0
        io_in[32] = 1'b1;
        tick(4);
        spi_frame(24'h80003E, 1'b1, 16'h0001, 1'b0);
        spi_frame(24'h80003F, 1'b1, 16'h0007, 1'b0);
        spi_frame(24'h800000, 1'b1, 16'h0002, 1'b0);
        spi_frame(24'h800001, 1'b1, 16'h0000, 1'b0);
        spi_frame(24'h800002, 1'b1, 16'h0004, 1'b0);
        spi_frame(24'h800003, 1'b1, 16'h003E, 1'b0);
        spi_frame(24'h800009, 1'b1, 16'h003E, 1'b0);
        io_in[32] = 1'b0;
        wait_gpio("wrap_out", 3'b111);
        tick(60);
        chk("wrap_hold", 64'(io_out[2:0]), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
